// File: rtl/cbus_arbiter_rr.sv
// Cache-bus payload types and an N-input arbiter that locks the cbus to one
// requester for a whole burst, using round-robin or fixed-priority selection.

package cbus_pkg;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned LEN_W  = 8;

   typedef struct packed {
      logic              valid;
      logic              is_write;
      logic [2:0]        size;
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
      logic [LEN_W-1:0]  len;
      logic [1:0]        burst;
   } cbus_req_t;

   typedef struct packed {
      logic              ready;
      logic              last;
      logic [DATA_W-1:0] data;
   } cbus_resp_t;
endpackage

module cbus_arbiter_rr
   import cbus_pkg::*;
#(
   parameter int unsigned NUM_INPUTS   = 2,
   parameter int unsigned RR_MODE      = 1,
   parameter int unsigned STARVE_LIMIT = 4,
   localparam int unsigned IW          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
   output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
   output cbus_req_t                    oreq,
   input  cbus_resp_t                   oresp,
   output logic                         grant_valid,
   output logic [IW-1:0]                grant_idx
);

   localparam int unsigned SW = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [SW-1:0] starve_q [NUM_INPUTS];
   logic [SW-1:0] starve_d [NUM_INPUTS];

   logic          win_valid;
   logic [IW-1:0] win_idx;

   // Winner selection, only consumed while IDLE
   always_comb begin : sel
      logic          found;
      int unsigned   j;
      logic [IW-1:0] idx;
      found   = 1'b0;
      j       = 0;
      idx     = '0;
      win_idx = '0;
      if (RR_MODE != 0) begin
         for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            j   = (32'(rr_ptr_q) + k) % NUM_INPUTS;
            idx = IW'(j);
            if (!found && ireqs[idx].valid) begin
               found   = 1'b1;
               win_idx = idx;
            end
         end
      end else begin
         // Starved requesters override plain priority
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (!found && ireqs[i].valid && (starve_q[i] >= SW'(STARVE_LIMIT))) begin
               found   = 1'b1;
               win_idx = IW'(i);
            end
         end
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (!found && ireqs[i].valid) begin
               found   = 1'b1;
               win_idx = IW'(i);
            end
         end
      end
      win_valid = found;
   end

   // Next state, grant bookkeeping and bus muxing
   always_comb begin : fsm
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      starve_d = starve_q;
      oreq     = '0;
      iresps   = '0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = BUSY;
               grant_d = win_idx;
               if (RR_MODE == 0) begin
                  for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                     if (IW'(i) == win_idx) begin
                        starve_d[i] = '0;
                     end else if (ireqs[i].valid) begin
                        starve_d[i] = (starve_q[i] >= SW'(STARVE_LIMIT)) ?
                                      SW'(STARVE_LIMIT) : starve_q[i] + 1'b1;
                     end else begin
                        starve_d[i] = '0;
                     end
                  end
               end
            end
         end
         BUSY: begin
            oreq            = ireqs[grant_q];
            iresps[grant_q] = oresp;
            if (oresp.ready && oresp.last) begin
               state_d = IDLE;
               if (RR_MODE != 0) begin
                  rr_ptr_d = (grant_q == IW'(NUM_INPUTS - 1)) ? '0 : grant_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            starve_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            starve_q[i] <= starve_d[i];
         end
      end
   end

   assign grant_valid = (state_q == BUSY);
   assign grant_idx   = grant_q;

endmodule

// File: doc/cbus_arbiter_rr.md
Name: cbus_arbiter_rr

Overview:
- Parametrised N-input arbiter for the cache-bus (cbus) between the L1 caches (icache, dcache, later uncached/prefetch channels) and the single outgoing cbus port.
- Selects one requester per transaction and locks the grant for the whole burst, until ready & last.
- Supports fixed-priority or round-robin selection.
- In fixed-priority mode, an anti-starvation counter promotes a requester that keeps losing.

Parameters:
- NUM_INPUTS, 2, number of requesting channels (1..8).
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority with index 0 highest.
- STARVE_LIMIT, 4, fixed-priority mode only: consecutive lost arbitrations before a waiting requester is force-granted (1..15).

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, asynchronous, active-low
- ireqs  input  NUM_INPUTS x cbus_req_t  per-channel requests (valid, is_write, size, addr, strobe, data, len, burst)
- iresps  output  NUM_INPUTS x cbus_resp_t  per-channel responses (ready, last, data)
- oreq  output  cbus_req_t  merged request to memory side
- oresp  input  cbus_resp_t  response from memory side
- grant_valid  output  1  a transaction is in flight
- grant_idx  output  max(1,$clog2(NUM_INPUTS))  index of the granted channel

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Reset (asserted at any time, including mid-burst): the following take effect immediately, not at the next clock edge.
  - State goes to IDLE.
  - oreq = '0 (valid 0).
  - All iresps = '0.
  - grant_valid = 0, grant_idx = 0.
  - rr_ptr = 0.
  - All starve counters = 0.
  - An in-flight burst is abandoned; no response reaches any channel.
- State machine has two states: IDLE and BUSY.
- IDLE:
  - oreq = '0 and all iresps = '0.
  - If any ireqs[i].valid is high, a winner is selected combinationally.
  - At the clock edge, grant_idx is registered with the winner and the state moves to BUSY.
  - If no request is valid, the block stays in IDLE.
- Selection, RR_MODE=1: first valid index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_INPUTS.
- Selection, RR_MODE=0:
  - If any valid requester i has starve[i] >= STARVE_LIMIT, the lowest such index wins.
  - Otherwise the lowest valid index wins.
- BUSY:
  - oreq = ireqs[grant_idx], passed through combinationally, so data and strobe follow the requester beat by beat.
  - iresps[grant_idx] = oresp; all other iresps = '0.
  - grant_valid = 1.
  - Non-granted requests stay pending and untouched; they are never dropped.
- Completion: when oresp.ready && oresp.last in BUSY, the state returns to IDLE at the next edge.
  - RR_MODE=1: rr_ptr <= (grant_idx+1) mod NUM_INPUTS.
  - There is at least one IDLE cycle between transactions, so back-to-back grants are 2 cycles apart minimum.
- Latency: a request that is valid in an IDLE cycle appears on oreq in the next cycle.
  - A single-beat transaction whose ready+last arrives in its first BUSY cycle occupies 2 cycles total.
- Starve counters (RR_MODE=0 only; held at 0 when RR_MODE=1):
  - Updated at each IDLE-to-BUSY edge.
  - The winner's counter is cleared.
  - Every other requester that was valid but lost increments its counter, saturating at STARVE_LIMIT.
  - A requester that is not valid at that edge clears its counter.
- Simultaneous events:
  - A request that becomes valid in the same cycle as ready+last is not granted in that cycle; it is evaluated in the following IDLE cycle.
  - A granted requester dropping valid mid-burst is a protocol violation. The block keeps forwarding ireqs[grant_idx] (valid 0) and stays in BUSY until last.
- Width: grant_idx and rr_ptr are max(1,$clog2(NUM_INPUTS)) bits. With NUM_INPUTS=1 the block degenerates to pass-through with the IDLE gap.
- No combinational path from oresp to oreq.

Test Plan:
- Reset then idle: resetn=0 mid-burst of a len=3 read on channel 1 → oreq.valid=0, iresps all 0, grant_valid=0 immediately; after release, rr_ptr=0.
- Single read, N=2, RR: ch0 valid (len=3, 4 beats) at cycle 0 → oreq.valid at cycle 1.
  - iresps[0] gets 4 beats; last beat at cycle k → IDLE at k+1; iresps[1] stays 0 throughout.
- Round-robin fairness, N=3, RR: all three requesters valid continuously with single-beat transactions → grant order 0,1,2,0,1,2; grant_idx observed every 2 cycles.
- Fixed priority + anti-starvation, N=2, RR_MODE=0, STARVE_LIMIT=4: ch0 and ch1 permanently valid → grants 0,0,0,0,1,0,0,0,0,1; starve[1] saturates at 4 before ch1 is granted.
- Burst lock: ch1 is granted a len=7 write; ch0 asserts valid at beat 2 → ch0 waits through all 8 beats and is granted in the first IDLE cycle after last; ch1's data and strobe match oreq every beat.
- Collision with completion: ch0 becomes valid in the cycle ch1 gets ready+last → ch0 is not granted that cycle; ch0 appears on oreq 2 cycles later.
